adder_tree_seq: RTL

- Multi-cycle sequencer for the 4-operand adder tree (sum1=a+b, sum2=c+d, sum3=sum1+sum2).
- One shared adder is time-multiplexed over the three tree additions under an FSM.
- Single-entry valid/ready input and output handshakes.
- Sits between an operand producer and a result consumer; trades three cycles of latency for one adder instead of three.

---
 rtl/adder_tree_seq_pkg.sv | 20 ++
 rtl/adder_tree_seq_shared_adder.sv | 12 +
 rtl/adder_tree_seq.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/adder_tree_seq_pkg.sv
// Shared types and width helpers for the time-multiplexed 4-operand adder tree.
package adder_tree_seq_pkg;

  localparam int DEF_A_W = 4;
  localparam int DEF_C_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    S_AB,
    S_CD,
    S_TOT,
    S_OUT
  } state_e;

  // Width of an unsigned sum of two w-bit values.
  function automatic int sum_w(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/adder_tree_seq_shared_adder.sv
// Combinational W-bit adder; callers zero-extend operands so no carry is lost.
module shared_adder #(
  parameter int W = 10
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  output logic [W-1:0] s_o
);

  assign s_o = x_i + y_i;

endmodule

// File: rtl/adder_tree_seq.sv
// Sequencer running a+b, c+d and their total through one shared adder.
// Optional statistics outputs are enabled by defining ADDER_TREE_SEQ_STATS_EN.
module adder_tree_seq
  import adder_tree_seq_pkg::*;
#(
  parameter int A_W = DEF_A_W,
  parameter int C_W = DEF_C_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] a,
  input  logic [A_W-1:0] b,
  input  logic [C_W-1:0] c,
  input  logic [C_W-1:0] d,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [A_W:0]   sum1,
  output logic [C_W:0]   sum2,
  output logic [C_W+1:0] sum3,
`ifdef ADDER_TREE_SEQ_STATS_EN
  output logic [15:0]    op_count,
  output logic [C_W+1:0] max_sum3,
`endif
  output logic           busy
);

  localparam int S1_W  = sum_w(A_W);
  localparam int S2_W  = sum_w(C_W);
  localparam int S3_W  = sum_w(S2_W);
  localparam int ADD_W = C_W + 2;

  state_e          state_q, state_d;
  logic [A_W-1:0]  a_q, a_d, b_q, b_d;
  logic [C_W-1:0]  c_q, c_d, d_q, d_d;
  logic [S1_W-1:0] sum1_q, sum1_d;
  logic [S2_W-1:0] sum2_q, sum2_d;
  logic [S3_W-1:0] sum3_q, sum3_d;
  logic            out_valid_q, out_valid_d;

  logic [ADD_W-1:0] add_x, add_y, add_s;
  logic             accept, out_hs;

  assign in_ready = (state_q == IDLE) || (state_q == S_OUT && out_ready);
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;

  // Operand select for the single adder; sum1 <= C_W+1 bits so every step fits ADD_W.
  always_comb begin
    add_x = '0;
    add_y = '0;
    case (state_q)
      S_AB:  begin add_x = ADD_W'(a_q);    add_y = ADD_W'(b_q);    end
      S_CD:  begin add_x = ADD_W'(c_q);    add_y = ADD_W'(d_q);    end
      S_TOT: begin add_x = ADD_W'(sum1_q); add_y = ADD_W'(sum2_q); end
      default: ;
    endcase
  end

  shared_adder #(.W(ADD_W)) u_add (
    .x_i (add_x),
    .y_i (add_y),
    .s_o (add_s)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    d_d         = d_q;
    sum1_d      = sum1_q;
    sum2_d      = sum2_q;
    sum3_d      = sum3_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      a_d = a;
      b_d = b;
      c_d = c;
      d_d = d;
    end
    case (state_q)
      IDLE:  if (accept) state_d = S_AB;
      S_AB:  begin sum1_d = add_s[S1_W-1:0]; state_d = S_CD;  end
      S_CD:  begin sum2_d = add_s[S2_W-1:0]; state_d = S_TOT; end
      S_TOT: begin
        sum3_d      = add_s[S3_W-1:0];
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d     = in_valid ? S_AB : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      sum1_q      <= '0;
      sum2_q      <= '0;
      sum3_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      d_q         <= d_d;
      sum1_q      <= sum1_d;
      sum2_q      <= sum2_d;
      sum3_q      <= sum3_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum1      = sum1_q;
  assign sum2      = sum2_q;
  assign sum3      = sum3_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);

`ifdef ADDER_TREE_SEQ_STATS_EN
  logic [15:0]     op_count_q, op_count_d;
  logic [S3_W-1:0] max_sum3_q, max_sum3_d;

  always_comb begin
    op_count_d = op_count_q;
    max_sum3_d = max_sum3_q;
    if (out_hs) begin
      op_count_d = op_count_q + 16'd1;
      if (sum3_q > max_sum3_q) max_sum3_d = sum3_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= '0;
      max_sum3_q <= '0;
    end else begin
      op_count_q <= op_count_d;
      max_sum3_q <= max_sum3_d;
    end
  end

  assign op_count = op_count_q;
  assign max_sum3 = max_sum3_q;
`else
  logic unused_hs;
  assign unused_hs = out_hs;
`endif

endmodule
